mem_responder: RTL

Memory-side responder for the multicycle RV32I core: serves the core's instruction-fetch, load and store requests from a single-ported word-organised memory. It accepts one request at a time over a valid/ready handshake, inserts a programmable number of wait states, applies RV32I byte/halfword lane selection and load extension from `funct3`, and returns read data or an access error on a separate valid/ready response channel.

---
 rtl/mem_responder.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder
//
// Memory-side responder for the multicycle RV32I core. Serves one fetch,
// load or store at a time from a single-ported, word-organised memory.
// After a request is accepted, a fixed number of wait states is inserted,
// and the access is performed. Read data or an access error is then
// returned on a separate valid/ready response channel.
//
// Parameters:
//   DEPTH_WORDS  memory size in 32-bit words (power of two)
//   WAIT_CYCLES  wait states between request accept and response (0..15)
//
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   req_valid / req_ready    request handshake (ready only while idle)
//   req_we                   1 = store, 0 = load/fetch
//   req_addr                 byte address
//   req_funct3               RV32I size/sign encoding
//   req_wdata                right-aligned store data
//   rsp_valid / rsp_ready    response handshake
//   rsp_rdata                extended load data (0 for stores and errors)
//   rsp_err                  misaligned, bad funct3 or out-of-range access
//
// The memory array "mem" is not reset. The bench may preload it
// hierarchically.

module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0]  cnt;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [2:0]  lat_funct3;
    logic [31:0] lat_wdata;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        do_access;
    logic        acc_we;
    logic [31:0] acc_addr;
    logic [2:0]  acc_funct3;
    logic [31:0] acc_wdata;
    logic [AW-1:0] word_idx;
    logic [31:0] old_word;
    logic [31:0] load_data;
    logic [31:0] store_word;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic        misaligned;
    logic        bad_funct3;
    logic        out_of_range;
    logic        acc_err;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && req_ready;

    // With zero wait states the access happens on the accept edge.
    // In that case, the request fields come straight from the inputs
    // rather than from the latched copy.
    assign acc_we     = (state == IDLE) ? req_we     : lat_we;
    assign acc_addr   = (state == IDLE) ? req_addr   : lat_addr;
    assign acc_funct3 = (state == IDLE) ? req_funct3 : lat_funct3;
    assign acc_wdata  = (state == IDLE) ? req_wdata  : lat_wdata;

    // resetn gates the access so that nothing touches memory while
    // reset is held, even on an accept edge with WAIT_CYCLES = 0.
    assign do_access = resetn &&
                       (((state == IDLE) && accept && (WAIT_CYCLES == 0)) ||
                        ((state == WAIT) && (cnt == 4'd1)));

    assign word_idx     = acc_addr[AW+1:2];
    assign old_word     = mem[word_idx];
    assign out_of_range = (acc_addr >> (AW + 2)) != 32'd0;
    assign acc_err      = misaligned || bad_funct3 || out_of_range;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = (WAIT_CYCLES > 0) ? WAIT : RESP;
            WAIT: if (cnt == 4'd1) state_next = RESP;
            RESP: if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Alignment and encoding checks. funct3[1:0] = 11 is never a legal
    // size. Stores additionally reject the unsigned variants, and loads
    // reject 110.
    always_comb begin
        misaligned = 1'b0;
        bad_funct3 = 1'b0;
        case (acc_funct3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = acc_addr[0];
            2'b10:   misaligned = |acc_addr[1:0];
            default: bad_funct3 = 1'b1;
        endcase
        if (acc_we && acc_funct3[2]) bad_funct3 = 1'b1;
        if (!acc_we && (acc_funct3 == 3'b110)) bad_funct3 = 1'b1;
    end

    always_comb begin
        case (acc_addr[1:0])
            2'b00:   byte_val = old_word[7:0];
            2'b01:   byte_val = old_word[15:8];
            2'b10:   byte_val = old_word[23:16];
            default: byte_val = old_word[31:24];
        endcase
        half_val = acc_addr[1] ? old_word[31:16] : old_word[15:0];
        case (acc_funct3)
            3'b000:  load_data = {{24{byte_val[7]}}, byte_val};
            3'b001:  load_data = {{16{half_val[15]}}, half_val};
            3'b010:  load_data = old_word;
            3'b100:  load_data = {24'b0, byte_val};
            3'b101:  load_data = {16'b0, half_val};
            default: load_data = 32'b0;
        endcase
    end

    // Store data is replicated across every lane. The mask then picks
    // the addressed lane(s), and the untouched lanes keep the old word.
    always_comb begin
        case (acc_funct3[1:0])
            2'b00: begin
                lane_mask = 32'h0000_00FF << {acc_addr[1:0], 3'b000};
                lane_data = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                lane_mask = acc_addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                lane_data = {2{acc_wdata[15:0]}};
            end
            default: begin
                lane_mask = 32'hFFFF_FFFF;
                lane_data = acc_wdata;
            end
        endcase
        store_word = (old_word & ~lane_mask) | (lane_data & lane_mask);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            lat_we     <= 1'b0;
            lat_addr   <= 32'd0;
            lat_funct3 <= 3'd0;
            lat_wdata  <= 32'd0;
            rsp_rdata  <= 32'd0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                lat_we     <= req_we;
                lat_addr   <= req_addr;
                lat_funct3 <= req_funct3;
                lat_wdata  <= req_wdata;
                cnt        <= 4'(WAIT_CYCLES);
            end else if ((state == WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (do_access) begin
                rsp_rdata <= (acc_we || acc_err) ? 32'd0 : load_data;
                rsp_err   <= acc_err;
            end
        end
    end

    // The memory has no reset, so its contents survive a reset.
    always_ff @(posedge clk) begin
        if (do_access && acc_we && !acc_err) begin
            mem[word_idx] <= store_word;
        end
    end

endmodule
